// File: rtl/cpc_busarb_pkg.sv
// Shared constants and helpers for the CPC backplane bus-request arbiter.
package cpc_busarb_pkg;

  localparam int unsigned NSLOTS_DEFAULT   = 4;
  localparam int unsigned HOLD_MAX_DEFAULT = 256;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRequest = 2'd1;
  localparam logic [1:0] StGrant   = 2'd2;
  localparam logic [1:0] StRelease = 2'd3;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpc_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module cpc_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);

  logic [W-1:0] cand;

  // Scan from farthest to nearest so the slot closest to ptr is written last and wins.
  always_comb begin
    idx   = '0;
    cand  = '0;
    valid = |req;
    for (int unsigned k = 0; k < N; k++) begin
      cand = W'((32'(ptr) + (N - 1 - k)) % N);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/cpc_busrq_arbiter.sv
// Z80 BUSRQ_B/BUSACK_B arbiter granting the bus round-robin to expansion slots.
// Optional hold watchdog enabled by defining CPC_BUSARB_WATCHDOG_EN.
module cpc_busrq_arbiter
  import cpc_busarb_pkg::*;
#(
  parameter int unsigned NSLOTS   = NSLOTS_DEFAULT,
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NSLOTS-1:0]            REQ,
  output logic [NSLOTS-1:0]            GNT,
  output logic                         BUSRQ_B,
  input  logic                         BUSACK_B,
  output logic [idx_width(NSLOTS)-1:0] OWNER,
  output logic                         BUSY,
  output logic                         TIMEOUT
);

  localparam int unsigned OW = idx_width(NSLOTS);

  if (NSLOTS < 2 || NSLOTS > 8 || HOLD_MAX < 1) begin : g_bad_param
    $error("cpc_busrq_arbiter: NSLOTS must be 2..8 and HOLD_MAX at least 1");
  end

  logic [1:0]        state_q, state_d;
  logic [NSLOTS-1:0] gnt_q, gnt_d;
  logic              busrq_b_q, busrq_b_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic              busy_q, busy_d;
  logic [OW-1:0]     rr_q, rr_d;
  logic              ack_meta_q, ack_s_q;

  logic [NSLOTS-1:0] eligible;
  logic [OW-1:0]     pick_idx;
  logic              pick_valid;
  logic [OW-1:0]     owner_next;

`ifdef CPC_BUSARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NSLOTS-1:0] mask_q, mask_d;
  logic              timeout_q, timeout_d;

  assign eligible = REQ & ~mask_q;
  assign TIMEOUT  = timeout_q;
`else
  assign eligible = REQ;
  assign TIMEOUT  = 1'b0;
`endif

  cpc_rr_pick #(
    .N (NSLOTS),
    .W (OW)
  ) u_pick (
    .req   (eligible),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign owner_next = (owner_q == OW'(NSLOTS - 1)) ? '0 : owner_q + OW'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busrq_b_d = busrq_b_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    rr_d      = rr_q;
`ifdef CPC_BUSARB_WATCHDOG_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    // A masked slot regains eligibility once its request is seen low.
    mask_d    = mask_q & REQ;
`endif
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d   = StRequest;
          owner_d   = pick_idx;
          busrq_b_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      StRequest: begin
        if (!ack_s_q) begin
          if (REQ[owner_q]) begin
            state_d = StGrant;
            gnt_d   = NSLOTS'(1) << owner_q;
`ifdef CPC_BUSARB_WATCHDOG_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d   = StRelease;
            busrq_b_d = 1'b1;
          end
        end
      end
      StGrant: begin
        if (!REQ[owner_q]) begin
          state_d   = StRelease;
          gnt_d     = '0;
          busrq_b_d = 1'b1;
`ifdef CPC_BUSARB_WATCHDOG_EN
        end else if (cnt_q == CntW'(HOLD_MAX - 1)) begin
          state_d   = StRelease;
          gnt_d     = '0;
          busrq_b_d = 1'b1;
          timeout_d = 1'b1;
          mask_d[owner_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      default: begin
        if (ack_s_q) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          rr_d    = owner_next;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      busrq_b_q  <= 1'b1;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      rr_q       <= '0;
      ack_meta_q <= 1'b1;
      ack_s_q    <= 1'b1;
`ifdef CPC_BUSARB_WATCHDOG_EN
      cnt_q      <= '0;
      mask_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      busrq_b_q  <= busrq_b_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      rr_q       <= rr_d;
      ack_meta_q <= BUSACK_B;
      ack_s_q    <= ack_meta_q;
`ifdef CPC_BUSARB_WATCHDOG_EN
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign GNT     = gnt_q;
  assign BUSRQ_B = busrq_b_q;
  assign OWNER   = owner_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_cpc_busrq_arbiter.sv
// Directed self-checking bench for cpc_busrq_arbiter (NSLOTS=4, HOLD_MAX=16).
module tb_cpc_busrq_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       busrq_b;
  logic       busack_b;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  cpc_busrq_arbiter #(
    .NSLOTS   (4),
    .HOLD_MAX (16)
  ) dut (
    .CLK      (clk),
    .RESET    (reset),
    .REQ      (req),
    .GNT      (gnt),
    .BUSRQ_B  (busrq_b),
    .BUSACK_B (busack_b),
    .OWNER    (owner),
    .BUSY     (busy),
    .TIMEOUT  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_busrq(input logic val);
    int n;
    n = 0;
    while (busrq_b !== val && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    while (gnt === 4'b0000 && n < 30) begin
      tick();
      n++;
    end
  endtask

  // Serve one owner: 4 GNT cycles, drop its request, re-raise it once back in IDLE.
  task automatic serve(input int exp_owner);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0001 << exp_owner;
    wait_busrq(1'b0);
    check_eq("rr_busrq_low", busrq_b, 0);
    check_eq("rr_owner", owner, exp_owner);
    busack_b = 1'b0;
    wait_gnt();
    check_eq("rr_gnt", gnt, exp_gnt);
    ticks(3);
    check_eq("rr_gnt_held", gnt, exp_gnt);
    req[exp_owner] = 1'b0;
    tick();
    check_eq("rr_gnt_off", gnt, 0);
    check_eq("rr_busrq_high", busrq_b, 1);
    busack_b = 1'b1;
    wait_idle();
    check_eq("rr_idle", busy, 0);
    req[exp_owner] = 1'b1;
  endtask

  initial begin
    logic to_seen;
    int   gcount;

    reset    = 1'b1;
    req      = 4'b1111;
    busack_b = 1'b1;

    // Reset holds everything quiet despite all requests high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rst_busrq", busrq_b, 1);
      check_eq("rst_gnt", gnt, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_owner", owner, 0);
      check_eq("rst_timeout", timeout, 0);
    end
    reset = 1'b0;
    req   = 4'b0000;
    tick();

    // Single request, cycle numbering relative to REQ rise.
    req = 4'b0001;
    tick();
    check_eq("s_busrq_c1", busrq_b, 0);
    check_eq("s_busy_c1", busy, 1);
    check_eq("s_owner_c1", owner, 0);
    ticks(4);
    busack_b = 1'b0;
    ticks(2);
    check_eq("s_gnt_c7", gnt, 0);
    tick();
    check_eq("s_gnt_c8", gnt, 4'b0001);
    ticks(12);
    req = 4'b0000;
    tick();
    check_eq("s_gnt_c21", gnt, 0);
    check_eq("s_busrq_c21", busrq_b, 1);
    check_eq("s_busy_c21", busy, 1);
    ticks(3);
    busack_b = 1'b1;
    ticks(2);
    check_eq("s_busy_c26", busy, 1);
    tick();
    check_eq("s_busy_c27", busy, 0);
    check_eq("s_timeout", timeout, 0);

    // Round-robin over 1011 from pointer 1: expect 1, 3, 0, 1.
    // (Pointer is 1 after slot 0 was served above.)
    req = 4'b1011;
    serve(1);
    serve(3);
    serve(0);
    serve(1);
    req = 4'b0000;
    tick();
    check_eq("rr_no_pick", busy, 0);

    // Abandon: pointer is 2; slot 2 drops before the Z80 acknowledges.
    req = 4'b0100;
    tick();
    check_eq("ab_owner", owner, 2);
    check_eq("ab_busrq_c1", busrq_b, 0);
    ticks(2);
    req = 4'b0000;
    ticks(3);
    busack_b = 1'b0;
    to_seen = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      tick();
      if (gnt !== 4'b0000) to_seen = 1'b1;
      if (c == 8) check_eq("ab_busrq_c8", busrq_b, 0);
    end
    check_eq("ab_gnt_never", to_seen, 0);
    check_eq("ab_busrq_c10", busrq_b, 1);
    check_eq("ab_busy_c10", busy, 1);
    ticks(2);
    busack_b = 1'b1;
    ticks(2);
    check_eq("ab_busy_c14", busy, 1);
    tick();
    check_eq("ab_busy_c15", busy, 0);

    // Reset mid-grant: pointer is 3, slot 3 takes the bus.
    req = 4'b1000;
    tick();
    check_eq("rg_owner", owner, 3);
    busack_b = 1'b0;
    ticks(4);
    to_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (timeout !== 1'b0) to_seen = 1'b1;
    end
    check_eq("rg_gnt", gnt, 4'b1000);
`ifndef CPC_BUSARB_WATCHDOG_EN
    for (int i = 0; i < 40; i++) begin
      tick();
      if (timeout !== 1'b0) to_seen = 1'b1;
    end
    check_eq("rg_gnt_long", gnt, 4'b1000);
`endif
    check_eq("rg_no_timeout", to_seen, 0);
    reset = 1'b1;
    tick();
    check_eq("rg_gnt_rst", gnt, 0);
    check_eq("rg_busrq_rst", busrq_b, 1);
    check_eq("rg_busy_rst", busy, 0);
    check_eq("rg_timeout_rst", timeout, 0);
    reset    = 1'b0;
    busack_b = 1'b1;
    req      = 4'b1111;
    tick();
    check_eq("rg_ptr_reset", owner, 0);
    check_eq("rg_busy_again", busy, 1);
    req      = 4'b0000;
    busack_b = 1'b0;
    wait_busrq(1'b1);
    check_eq("rg_abandon_busrq", busrq_b, 1);
    busack_b = 1'b1;
    wait_idle();
    check_eq("rg_idle", busy, 0);

`ifdef CPC_BUSARB_WATCHDOG_EN
    // Watchdog: pointer is 1; slot 1 holds its request forever.
    req = 4'b0010;
    wait_busrq(1'b0);
    check_eq("wd_owner", owner, 1);
    busack_b = 1'b0;
    wait_gnt();
    gcount = 0;
    while (gnt !== 4'b0000 && gcount < 40) begin
      check_eq("wd_timeout_low", timeout, 0);
      gcount++;
      tick();
    end
    check_eq("wd_gnt_cycles", gcount, 16);
    check_eq("wd_timeout_pulse", timeout, 1);
    check_eq("wd_busrq_high", busrq_b, 1);
    tick();
    check_eq("wd_timeout_single", timeout, 0);
    busack_b = 1'b1;
    wait_idle();
    check_eq("wd_idle", busy, 0);
    ticks(5);
    check_eq("wd_masked", busy, 0);
    req = 4'b0011;
    tick();
    check_eq("wd_slot0_busy", busy, 1);
    check_eq("wd_slot0_owner", owner, 0);
    req      = 4'b0000;
    busack_b = 1'b0;
    wait_busrq(1'b1);
    busack_b = 1'b1;
    wait_idle();
    check_eq("wd_end_idle", busy, 0);
`else
    gcount = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
